// File: rtl/midi_note_tx.sv
// MIDI note event encoder: queues note events in a small FIFO and serialises them as
// MIDI 1.0 messages (status + two data bytes) on a 31250-baud UART line.
module midi_note_tx #(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned BAUD           = 31250,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned RUNNING_STATUS = 1
) (
    input  logic                          CLOCK_50,
    input  logic                          reset_reg_N,
    input  logic                          ev_valid_i,
    output logic                          ev_ready_o,
    input  logic [1:0]                    ev_type_i,
    input  logic [3:0]                    ev_chan_i,
    input  logic [6:0]                    ev_key_i,
    input  logic [6:0]                    ev_vel_i,
    output logic                          midi_txd_o,
    output logic                          tx_busy_o,
    output logic                          ev_dropped_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int unsigned Div  = CLK_HZ / BAUD;
    localparam int unsigned CntW = $clog2(Div);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    // Event word: [19:18] type, [17:14] channel, [13:7] key, [6:0] velocity
    localparam int unsigned EvW = 20;

    typedef enum logic [2:0] {StIdle, StPop, StSendS, StSendD1, StSendD2} state_e;

    // ---------------- event FIFO ----------------
    logic [EvW-1:0]  mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0] count_q, count_d;
    logic            push, pop, empty;
    logic [EvW-1:0]  head;

    assign ev_ready_o   = (count_q != LvlW'(FIFO_DEPTH));
    assign empty        = (count_q == '0);
    assign push         = ev_valid_i & ev_ready_o;
    assign head         = mem_q[rd_ptr_q];
    assign fifo_level_o = count_q;
    assign count_d      = count_q + LvlW'(push) - LvlW'(pop);

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ev_type_i, ev_chan_i, ev_key_i, ev_vel_i};
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    // ---------------- message encoding ----------------
    function automatic logic [7:0] status_of(input logic [EvW-1:0] ev);
        case (ev[19:18])
            2'b00:   status_of = {4'h8, ev[17:14]};
            2'b01:   status_of = {4'h9, ev[17:14]};
            default: status_of = {4'hB, ev[17:14]};
        endcase
    endfunction

    function automatic logic [7:0] d1_of(input logic [EvW-1:0] ev);
        d1_of = (ev[19:18] == 2'b10) ? 8'h7B : {1'b0, ev[13:7]};
    endfunction

    function automatic logic [7:0] d2_of(input logic [EvW-1:0] ev);
        d2_of = (ev[19:18] == 2'b10) ? 8'h00 : {1'b0, ev[6:0]};
    endfunction

    // ---------------- control FSM ----------------
    state_e         state_q, state_d;
    logic [EvW-1:0] msg_q, msg_d;
    logic [7:0]     last_status_q, last_status_d;
    logic           last_valid_q, last_valid_d;
    logic           sh_load, sh_done, start;
    logic [7:0]     sh_byte;
    logic [EvW-1:0] sel_ev;
    logic [7:0]     sel_s;

    // A message starts either from the popped entry (StPop) or straight from the FIFO head
    // when the previous stop bit ends, which keeps consecutive messages gap-free.
    assign sel_ev = (state_q == StPop) ? msg_q : head;
    assign sel_s  = status_of(sel_ev);

    always_comb begin
        state_d       = state_q;
        msg_d         = msg_q;
        last_status_d = last_status_q;
        last_valid_d  = last_valid_q;
        pop           = 1'b0;
        start         = 1'b0;
        sh_load       = 1'b0;
        sh_byte       = 8'h00;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    msg_d   = head;
                    state_d = StPop;
                end
            end
            StPop: begin
                if (msg_q[19:18] == 2'b11) state_d = StIdle;
                else                       start   = 1'b1;
            end
            StSendS: begin
                if (sh_done) begin
                    sh_load = 1'b1;
                    sh_byte = d1_of(msg_q);
                    state_d = StSendD1;
                end
            end
            StSendD1: begin
                if (sh_done) begin
                    sh_load = 1'b1;
                    sh_byte = d2_of(msg_q);
                    state_d = StSendD2;
                end
            end
            StSendD2: begin
                if (sh_done) begin
                    if (!empty) begin
                        pop   = 1'b1;
                        msg_d = head;
                        if (head[19:18] == 2'b11) state_d = StPop;
                        else                      start   = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            sh_load = 1'b1;
            if (RUNNING_STATUS == 0 || !last_valid_q || sel_s != last_status_q) begin
                sh_byte       = sel_s;
                last_status_d = sel_s;
                last_valid_d  = 1'b1;
                state_d       = StSendS;
            end else begin
                sh_byte = d1_of(sel_ev);
                state_d = StSendD1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q       <= StIdle;
            msg_q         <= '0;
            last_status_q <= 8'h00;
            last_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            msg_q         <= msg_d;
            last_status_q <= last_status_d;
            last_valid_q  <= last_valid_d;
        end
    end

    assign ev_dropped_o = (state_q == StPop) && (msg_q[19:18] == 2'b11);
    assign tx_busy_o    = (state_q != StIdle) || !empty;

    // ---------------- UART shifter ----------------
    logic            sh_active_q;
    logic [3:0]      bit_cnt_q;
    logic [CntW-1:0] baud_cnt_q;
    logic [7:0]      sh_data_q;
    logic            baud_end;

    assign baud_end = (baud_cnt_q == CntW'(Div - 1));
    assign sh_done  = sh_active_q && baud_end && (bit_cnt_q == 4'd9);

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            sh_active_q <= 1'b0;
            bit_cnt_q   <= 4'd0;
            baud_cnt_q  <= '0;
            sh_data_q   <= 8'h00;
        end else if (sh_load) begin
            sh_active_q <= 1'b1;
            bit_cnt_q   <= 4'd0;
            baud_cnt_q  <= '0;
            sh_data_q   <= sh_byte;
        end else if (sh_active_q) begin
            if (baud_end) begin
                baud_cnt_q <= '0;
                if (bit_cnt_q == 4'd9) sh_active_q <= 1'b0;
                else                   bit_cnt_q   <= bit_cnt_q + 4'd1;
                // Data bits are presented from bit 0 of the register, so shift after each one
                if (bit_cnt_q >= 4'd1 && bit_cnt_q <= 4'd8) sh_data_q <= sh_data_q >> 1;
            end else begin
                baud_cnt_q <= baud_cnt_q + CntW'(1);
            end
        end
    end

    always_comb begin
        midi_txd_o = 1'b1;
        if (sh_active_q) begin
            if (bit_cnt_q == 4'd0)      midi_txd_o = 1'b0;
            else if (bit_cnt_q == 4'd9) midi_txd_o = 1'b1;
            else                        midi_txd_o = sh_data_q[0];
        end
    end

endmodule

// File: tb/tb_midi_note_tx.sv
// Scoreboard bench for midi_note_tx: two instances (running status on / off), a UART
// receiver per instance pops expected bytes and checks value, stop bit and contiguity.
module tb_midi_note_tx;

    localparam int DIV = 16;
    localparam int unsigned CLK_HZ = DIV * 31250;
    localparam int MSG3 = 3 * 10 * DIV + 2;
    localparam int MSG2 = 2 * 10 * DIV + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] ev_valid = 2'b00;
    logic [1:0] ev_ready, txd, busy, dropped;
    logic [1:0] ev_type [2];
    logic [3:0] ev_chan [2];
    logic [6:0] ev_key  [2];
    logic [6:0] ev_vel  [2];
    logic [2:0] level   [2];

    typedef struct packed {logic [7:0] b; logic contig;} exp_t;
    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int drop0 = 0;
    int drop1 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (dropped[0]) drop0++;
        if (dropped[1]) drop1++;
    end

    midi_note_tx #(.CLK_HZ(CLK_HZ), .BAUD(31250), .FIFO_DEPTH(4), .RUNNING_STATUS(1)) u_rs (
        .CLOCK_50(clk), .reset_reg_N(rst_n),
        .ev_valid_i(ev_valid[0]), .ev_ready_o(ev_ready[0]),
        .ev_type_i(ev_type[0]), .ev_chan_i(ev_chan[0]),
        .ev_key_i(ev_key[0]), .ev_vel_i(ev_vel[0]),
        .midi_txd_o(txd[0]), .tx_busy_o(busy[0]),
        .ev_dropped_o(dropped[0]), .fifo_level_o(level[0])
    );

    midi_note_tx #(.CLK_HZ(CLK_HZ), .BAUD(31250), .FIFO_DEPTH(4), .RUNNING_STATUS(0)) u_nors (
        .CLOCK_50(clk), .reset_reg_N(rst_n),
        .ev_valid_i(ev_valid[1]), .ev_ready_o(ev_ready[1]),
        .ev_type_i(ev_type[1]), .ev_chan_i(ev_chan[1]),
        .ev_key_i(ev_key[1]), .ev_vel_i(ev_vel[1]),
        .midi_txd_o(txd[1]), .tx_busy_o(busy[1]),
        .ev_dropped_o(dropped[1]), .fifo_level_o(level[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_b(input int id, input logic [7:0] b, input logic c);
        exp_t e;
        e.b = b;
        e.contig = c;
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    task automatic exp3(input int id, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic c0);
        expect_b(id, b0, c0);
        expect_b(id, b1, 1'b1);
        expect_b(id, b2, 1'b1);
    endtask

    task automatic exp2(input int id, input logic [7:0] b0, input logic [7:0] b1);
        expect_b(id, b0, 1'b0);
        expect_b(id, b1, 1'b1);
    endtask

    // Returns just after the accepting posedge.
    task automatic push_ev(input int id, input logic [1:0] t, input logic [3:0] c,
                           input logic [6:0] k, input logic [6:0] v);
        int n = 0;
        @(negedge clk);
        ev_valid[id] = 1'b1;
        ev_type[id]  = t;
        ev_chan[id]  = c;
        ev_key[id]   = k;
        ev_vel[id]   = v;
        while (!ev_ready[id] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("push ready timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    // Called right after push_ev; measures busy duration and first-byte latency.
    task automatic run_msg(input int id, input int exp_cyc, input bit lat);
        int  n = 0;
        bit  done = 0;
        for (int i = 1; i <= 5000 && !done; i++) begin
            @(negedge clk);
            if (i == 1) begin
                ev_valid[id] = 1'b0;
                chk("busy after accept", busy[id], 1);
            end
            if (lat && i == 2) chk("line idle before load", txd[id], 1);
            if (lat && i == 3) chk("start bit latency", txd[id], 0);
            if (busy[id]) n++;
            else          done = 1;
        end
        chk("busy cycles", n, exp_cyc);
        chk("txd idle after", txd[id], 1);
    endtask

    task automatic wait_idle(input int id);
        int n = 0;
        @(negedge clk);
        while (busy[id] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle timeout", busy[id], 0);
        chk("txd idle", txd[id], 1);
    endtask

    task automatic mon(input int id);
        logic       prev = 1'b1;
        logic [7:0] d;
        logic       stop;
        bit         ab;
        int         st;
        int         prev_st = -100000;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !txd[id]) begin
                st = cyc;
                ab = !rst_n;
                repeat (DIV / 2) begin @(negedge clk); if (!rst_n) ab = 1; end
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) begin @(negedge clk); if (!rst_n) ab = 1; end
                    d[i] = txd[id];
                end
                repeat (DIV) begin @(negedge clk); if (!rst_n) ab = 1; end
                stop = txd[id];
                if (!ab) begin
                    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
                        chk("unexpected byte", {24'd0, d}, 32'hFFFF_FFFF);
                    end else begin
                        e = (id == 0) ? q0.pop_front() : q1.pop_front();
                        chk("byte value", d, e.b);
                        chk("stop bit", stop, 1);
                        if (e.contig) chk("byte contiguity", st - prev_st, 10 * DIV);
                    end
                    prev_st = st;
                end
            end
            prev = txd[id];
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int d;
        for (int i = 0; i < 2; i++) begin
            ev_type[i] = 2'b00; ev_chan[i] = 4'h0; ev_key[i] = 7'h0; ev_vel[i] = 7'h0;
        end
        #2 rst_n = 1'b0;
        fork
            mon(0);
            mon(1);
        join_none
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset txd", txd[i], 1);
            chk("reset busy", busy[i], 0);
            chk("reset dropped", dropped[i], 0);
            chk("reset level", level[i], 0);
            chk("reset ready", ev_ready[i], 1);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Note-on with status, then running status, then status change
        exp3(0, 8'h90, 8'h3C, 8'h64, 1'b0);
        push_ev(0, 2'b01, 4'd0, 7'd60, 7'd100);
        run_msg(0, MSG3, 1'b1);
        exp2(0, 8'h40, 8'h5A);
        push_ev(0, 2'b01, 4'd0, 7'd64, 7'd90);
        run_msg(0, MSG2, 1'b1);
        exp3(0, 8'h83, 8'h3C, 8'h00, 1'b0);
        push_ev(0, 2'b00, 4'd3, 7'd60, 7'd0);
        run_msg(0, MSG3, 1'b1);

        // All-notes-off, then a reserved event that only pulses ev_dropped
        exp3(0, 8'hBF, 8'h7B, 8'h00, 1'b0);
        push_ev(0, 2'b10, 4'd15, 7'd5, 7'd9);
        run_msg(0, MSG3, 1'b1);
        d = drop0;
        push_ev(0, 2'b11, 4'd2, 7'd5, 7'd6);
        run_msg(0, 2, 1'b0);
        chk("dropped pulses", drop0 - d, 1);

        // Running status disabled: status repeated
        exp3(1, 8'h90, 8'h3C, 8'h64, 1'b0);
        push_ev(1, 2'b01, 4'd0, 7'd60, 7'd100);
        run_msg(1, MSG3, 1'b1);
        exp3(1, 8'h90, 8'h40, 8'h5A, 1'b0);
        push_ev(1, 2'b01, 4'd0, 7'd64, 7'd90);
        run_msg(1, MSG3, 1'b1);

        // Burst of five events: FIFO fills, 15 bytes back-to-back
        exp3(1, 8'h92, 8'h01, 8'h02, 1'b0);
        exp3(1, 8'h92, 8'h03, 8'h04, 1'b1);
        exp3(1, 8'h85, 8'h7F, 8'h7F, 1'b1);
        exp3(1, 8'hB0, 8'h7B, 8'h00, 1'b1);
        exp3(1, 8'h99, 8'h00, 8'h00, 1'b1);
        push_ev(1, 2'b01, 4'd2, 7'd1, 7'd2);
        push_ev(1, 2'b01, 4'd2, 7'd3, 7'd4);
        push_ev(1, 2'b00, 4'd5, 7'd127, 7'd127);
        push_ev(1, 2'b10, 4'd0, 7'd0, 7'd0);
        push_ev(1, 2'b01, 4'd9, 7'd0, 7'd0);
        @(negedge clk);
        ev_valid[1] = 1'b0;
        chk("burst level full", level[1], 4);
        chk("burst ready low", ev_ready[1], 0);
        wait_idle(1);
        chk("burst level drained", level[1], 0);

        // Reset mid-byte with a second entry queued
        push_ev(0, 2'b01, 4'd1, 7'd10, 7'd20);
        push_ev(0, 2'b01, 4'd1, 7'd11, 7'd21);
        @(negedge clk);
        ev_valid[0] = 1'b0;
        repeat (30) @(negedge clk);
        chk("queued before reset", level[0], 1);
        d = 0;
        while (txd[0] && d < 200) begin
            @(negedge clk);
            d++;
        end
        chk("found low bit", txd[0], 0);
        rst_n = 1'b0;
        #1;
        chk("reset txd immediate", txd[0], 1);
        chk("reset flushes fifo", level[0], 0);
        chk("reset clears busy", busy[0], 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        exp3(0, 8'h91, 8'h0A, 8'h14, 1'b0);
        push_ev(0, 2'b01, 4'd1, 7'd10, 7'd20);
        run_msg(0, MSG3, 1'b1);

        repeat (20) @(negedge clk);
        chk("scoreboard 0 drained", q0.size(), 0);
        chk("scoreboard 1 drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
